// File: rtl/score_string_builder_pkg.sv
// Shared display constants and the converter FSM state type.
package score_string_builder_pkg;

  // Default glyph indices into the character strip
  localparam int DISP_DIGIT_BASE  = 0;
  localparam int DISP_BLANK_CODE  = 10;
  localparam int DISP_GLYPH_WIDTH = 15;
  localparam int DISP_NUM_DIGITS  = 10;
  localparam int DISP_BCD_WIDTH   = 4 * DISP_NUM_DIGITS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    WAIT_VB = 2'd2
  } ssb_state_t;

endpackage

// File: rtl/score_string_builder_dd_nibble_adjust.sv
// Double-dabble correction for one BCD nibble: add 3 when the digit is 5 or more.
module dd_nibble_adjust (
  input  logic [3:0] nibble_in,
  output logic [3:0] nibble_out
);

  assign nibble_out = (nibble_in >= 4'd5) ? nibble_in + 4'd3 : nibble_in;

endmodule

// File: rtl/score_string_builder.sv
// Binary-to-decimal score renderer: serial double-dabble conversion, then a
// vblank-synchronised commit of ten character codes.
module score_string_builder
  import score_string_builder_pkg::*;
#(
  parameter int CNT_WIDTH  = 10,
  parameter int VAL_WIDTH  = 32,
  parameter int DIGIT_BASE = DISP_DIGIT_BASE,
  parameter int BLANK_CODE = DISP_BLANK_CODE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic [VAL_WIDTH-1:0] value,
  input  logic                 lz_blank,
  input  logic                 vblank,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] char_1,
  output logic [CNT_WIDTH-1:0] char_2,
  output logic [CNT_WIDTH-1:0] char_3,
  output logic [CNT_WIDTH-1:0] char_4,
  output logic [CNT_WIDTH-1:0] char_5,
  output logic [CNT_WIDTH-1:0] char_6,
  output logic [CNT_WIDTH-1:0] char_7,
  output logic [CNT_WIDTH-1:0] char_8,
  output logic [CNT_WIDTH-1:0] char_9,
  output logic [CNT_WIDTH-1:0] char_10
);

  localparam int CW = $clog2(VAL_WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(VAL_WIDTH - 1);

  ssb_state_t                state_q;
  logic [VAL_WIDTH-1:0]      val_sr_q;
  logic [DISP_BCD_WIDTH-1:0] bcd_q;
  logic [DISP_BCD_WIDTH-1:0] adj;
  logic [DISP_BCD_WIDTH-1:0] bcd_next;
  logic [CW-1:0]             cnt_q;
  logic                      lz_q;
  logic                      pending_q;
  logic                      restart_q;
  logic [CNT_WIDTH-1:0]      chars_q  [DISP_NUM_DIGITS];
  logic [CNT_WIDTH-1:0]      rendered [DISP_NUM_DIGITS];
  logic                      seen_nz;
  logic [3:0]                digit;

  for (genvar g = 0; g < DISP_NUM_DIGITS; g++) begin : g_adj
    dd_nibble_adjust u_adj (
      .nibble_in  (bcd_q[4*g +: 4]),
      .nibble_out (adj[4*g +: 4])
    );
  end

  // Top nibble's carry-out is discarded by the shift; it cannot be nonzero for <=10-digit values.
  assign bcd_next = (adj << 1) | DISP_BCD_WIDTH'(val_sr_q[VAL_WIDTH-1]);

  // Map BCD digits to glyph codes, blanking zeros left of the first nonzero digit.
  always_comb begin
    seen_nz = 1'b0;
    digit   = '0;
    for (int unsigned i = 0; i < DISP_NUM_DIGITS; i++) begin
      digit = bcd_q[4*(DISP_NUM_DIGITS-1-i) +: 4];
      if (digit != 4'd0 || i == DISP_NUM_DIGITS - 1) seen_nz = 1'b1;
      rendered[i] = (lz_q && !seen_nz) ? CNT_WIDTH'(BLANK_CODE)
                                       : CNT_WIDTH'(DIGIT_BASE) + CNT_WIDTH'(digit);
    end
  end

  // Control FSM: accept, convert one bit per cycle, commit on vblank.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pending_q <= 1'b0;
      restart_q <= 1'b0;
      lz_q      <= 1'b0;
      cnt_q     <= '0;
      val_sr_q  <= '0;
      bcd_q     <= '0;
      for (int unsigned i = 0; i < DISP_NUM_DIGITS; i++) chars_q[i] <= CNT_WIDTH'(BLANK_CODE);
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req || restart_q) begin
            val_sr_q  <= value;
            lz_q      <= lz_blank;
            bcd_q     <= '0;
            cnt_q     <= '0;
            busy      <= 1'b1;
            restart_q <= 1'b0;
            state_q   <= CONVERT;
          end
        end
        CONVERT: begin
          if (req) pending_q <= 1'b1;
          bcd_q    <= bcd_next;
          val_sr_q <= val_sr_q << 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) state_q <= WAIT_VB;
        end
        WAIT_VB: begin
          if (vblank) begin
            for (int unsigned i = 0; i < DISP_NUM_DIGITS; i++) chars_q[i] <= rendered[i];
            done      <= 1'b1;
            busy      <= 1'b0;
            // A queued or coincident request restarts from IDLE on the next edge.
            restart_q <= pending_q | req;
            pending_q <= 1'b0;
            state_q   <= IDLE;
          end else if (req) begin
            pending_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign char_1  = chars_q[0];
  assign char_2  = chars_q[1];
  assign char_3  = chars_q[2];
  assign char_4  = chars_q[3];
  assign char_5  = chars_q[4];
  assign char_6  = chars_q[5];
  assign char_7  = chars_q[6];
  assign char_8  = chars_q[7];
  assign char_9  = chars_q[8];
  assign char_10 = chars_q[9];

endmodule

// File: doc/score_string_builder.md
SCORE_STRING_BUILDER -- requirements
Module: score_string_builder

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 10, width of each character code output.
REQ-002 SHALL have parameter VAL_WIDTH, default 32, width of the binary value input (at most 10 decimal digits).
REQ-003 SHALL have parameter DIGIT_BASE, default 0, character-strip index of glyph '0'; glyph d is at DIGIT_BASE+d.
REQ-004 SHALL have parameter BLANK_CODE, default 10, character-strip index of the blank glyph.
REQ-005 SHALL have port clk, input, 1, the single clock domain.
REQ-006 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-007 SHALL have port req, input, 1, sampled each cycle; high requests conversion of value.
REQ-008 SHALL have port value, input, VAL_WIDTH, unsigned binary number to render.
REQ-009 SHALL have port lz_blank, input, 1, high suppresses leading zeros; sampled with value.
REQ-010 SHALL have port vblank, input, 1, high while the display is outside the visible area.
REQ-011 SHALL have port busy, output, 1, high from request acceptance until commit.
REQ-012 SHALL have port done, output, 1, one-cycle pulse after character outputs update.
REQ-013 SHALL have ports char_1 .. char_10, output, CNT_WIDTH each; char_1 is the leftmost (most significant) digit.

Function
REQ-014 SHALL implement FSM IDLE -> CONVERT -> WAIT_VB -> IDLE.
REQ-015 In IDLE with req=1 at edge E0: latch value and lz_blank, clear the 40-bit BCD register, go to CONVERT, and drive busy=1 from E0.
REQ-016 CONVERT SHALL perform one double-dabble iteration per cycle: add 3 to every BCD nibble >= 5, then shift left one bit, with the value MSB entering.
REQ-017 CONVERT SHALL last exactly VAL_WIDTH cycles (edges E1..E32 at default), then enter WAIT_VB.
REQ-018 In WAIT_VB, the first edge with vblank=1 SHALL load all char outputs, set done=1 for one cycle, drop busy, and return to IDLE.
REQ-019 At default widths and with vblank held high, outputs and done SHALL be visible after edge E33.
REQ-020 Char outputs SHALL change only on the commit edge; they are never partially updated.
REQ-021 Leading-zero suppression (lz_blank=1): every digit left of the most significant nonzero digit SHALL be BLANK_CODE; value 0 SHALL render BLANK_CODE in char_1..char_9 and DIGIT_BASE in char_10.
REQ-022 With lz_blank=0, all ten digits SHALL render as DIGIT_BASE+d.
REQ-023 A req arriving while busy SHALL set a single pending flag; further reqs while pending SHALL be absorbed.
REQ-024 If the pending flag is set at commit, the FSM SHALL clear it and re-enter CONVERT on the next edge, latching value at that edge; busy SHALL be deasserted for exactly the done cycle.
REQ-025 A req coincident with the commit edge SHALL set pending (REQ-024 applies).
REQ-026 Arithmetic SHALL be unsigned; no digit can exceed 9 after the adjust step.

Reset
REQ-027 rst=1 on a clock edge SHALL force IDLE, busy=0, done=0, clear the pending flag, and set char_1..char_10=BLANK_CODE.
REQ-028 rst SHALL take priority over every other input, including mid-CONVERT and in WAIT_VB; no done pulse SHALL follow an aborted conversion.

Structure
REQ-029 The shared display package SHALL hold DIGIT_BASE, BLANK_CODE, character glyph width 15, digit count 10, and the FSM state encoding.
REQ-030 One sub-module, dd_nibble_adjust (4-bit add-3-if->=5), SHALL be instantiated ten times.

Verification
REQ-031 value=1234567890, lz_blank=0, vblank=1, req pulse -> after E33 chars = 1,2,3,4,5,6,7,8,9,0 (DIGIT_BASE-relative); done is high for 1 cycle.
REQ-032 value=42, lz_blank=1 -> char_1..8=BLANK_CODE, char_9=4, char_10=2; value=0 -> only char_10=0.
REQ-033 vblank=0 until 100 cycles after req -> busy stays high, chars unchanged, commit on the first vblank=1 edge.
REQ-034 A second req at E10 carrying value 7 -> first result commits, then a reconversion starts on the next edge, and chars become ...,7 with a second done pulse.
REQ-035 rst asserted at E15 of CONVERT -> all chars BLANK_CODE and busy=0 on the next cycle; no done pulse; a fresh req then converts normally.
REQ-036 value=4294967295, lz_blank=0 -> chars = 4,2,9,4,9,6,7,2,9,5.
